// File: rtl/decode_stage_if.sv
// Purpose: handshake and decoded-bundle bus of the RV32I decode stage.
// Fetch side : in_valid, in_ready, inst, in_pc, flush
// Execute side: out_valid, out_ready, out_pc, rd, rs1_addr, rs2_addr, alu_op,
//               addr_alu_op, funct3, imm, wb_sel, reg_we, mem_rd, mem_wr,
//               branch, jump, illegal
// Modports: slave = the decode stage, master = its fetch/execute neighbours.
interface decode_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      rd;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [2:0]      alu_op;
    logic [1:0]      addr_alu_op;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [1:0]      wb_sel;
    logic            reg_we;
    logic            mem_rd;
    logic            mem_wr;
    logic            branch;
    logic            jump;
    logic            illegal;

    modport slave (
        input  in_valid, inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, rd, rs1_addr, rs2_addr, alu_op,
               addr_alu_op, funct3, imm, wb_sel, reg_we, mem_rd, mem_wr,
               branch, jump, illegal
    );

    modport master (
        output in_valid, inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, rd, rs1_addr, rs2_addr, alu_op,
               addr_alu_op, funct3, imm, wb_sel, reg_we, mem_rd, mem_wr,
               branch, jump, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// Purpose: registered RV32I instruction-decode stage holding one entry.
// Ports: clk, rst_n (async active-low), bus (decode_stage_if.slave) carrying
//        the fetch handshake (inst/in_pc) and the decoded execute bundle.
// in_ready is combinational; every other output is registered.
module decode_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    decode_stage_if.slave bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Registered outputs
    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [4:0]      r_rd, r_rs1, r_rs2;
    logic [2:0]      r_alu_op, r_funct3;
    logic [1:0]      r_addr_op, r_wb_sel;
    logic [XLEN-1:0] r_imm;
    logic            r_reg_we, r_mem_rd, r_mem_wr, r_branch, r_jump, r_illegal;

    // Combinational decode of the incoming word
    logic [31:0] w_inst;
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_r;
    logic [31:0] w_imm;
    logic [2:0]  w_alu_op;
    logic [1:0]  w_addr_op, w_wb_sel;
    logic        w_reg_we, w_mem_rd, w_mem_wr, w_branch, w_jump, w_illegal;
    logic        w_in_ready, w_capture;

    assign w_inst = bus.inst;
    assign w_opc  = w_inst[6:0];
    assign w_f3   = w_inst[14:12];

    assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25],
                      w_inst[11:8], 1'b0};
    assign w_imm_u = {w_inst[31:12], 12'b0};
    assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20],
                      w_inst[30:21], 1'b0};
    // OP carries funct7 in imm[11:5] so the ALU can pick ADD/SUB, SRL/SRA
    assign w_imm_r = {20'b0, w_inst[31:25], 5'b0};

    // Per-opcode control decode; illegal encodings drop all side effects
    always_comb begin
        w_imm     = '0;
        w_alu_op  = 3'd0;
        w_addr_op = 2'd0;
        w_wb_sel  = 2'd0;
        w_reg_we  = 1'b0;
        w_mem_rd  = 1'b0;
        w_mem_wr  = 1'b0;
        w_branch  = 1'b0;
        w_jump    = 1'b0;
        w_illegal = 1'b0;

        if (w_inst[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end else begin
            unique case (w_opc)
                OPC_LUI: begin
                    w_imm    = w_imm_u;
                    w_reg_we = 1'b1;
                end
                OPC_AUIPC: begin
                    w_imm     = w_imm_u;
                    w_addr_op = 2'd1;
                    w_wb_sel  = 2'd1;
                    w_reg_we  = 1'b1;
                end
                OPC_JAL: begin
                    w_imm     = w_imm_j;
                    w_alu_op  = 3'd1;
                    w_addr_op = 2'd1;
                    w_reg_we  = 1'b1;
                    w_jump    = 1'b1;
                end
                OPC_JALR: begin
                    w_imm     = w_imm_i;
                    w_alu_op  = 3'd1;
                    w_addr_op = 2'd2;
                    w_reg_we  = 1'b1;
                    w_jump    = 1'b1;
                    w_illegal = (w_f3 != 3'b000);
                end
                OPC_BRANCH: begin
                    w_imm     = w_imm_b;
                    w_addr_op = 2'd1;
                    w_branch  = 1'b1;
                    w_illegal = (w_f3 == 3'b010) || (w_f3 == 3'b011);
                end
                OPC_LOAD: begin
                    w_imm     = w_imm_i;
                    w_addr_op = 2'd2;
                    w_wb_sel  = 2'd2;
                    w_mem_rd  = 1'b1;
                    w_reg_we  = 1'b1;
                    w_illegal = (w_f3 == 3'b011) || (w_f3 == 3'b110) ||
                                (w_f3 == 3'b111);
                end
                OPC_STORE: begin
                    w_imm     = w_imm_s;
                    w_alu_op  = 3'd4;
                    w_addr_op = 2'd2;
                    w_mem_wr  = 1'b1;
                    w_illegal = (w_f3 > 3'b010);
                end
                OPC_OPIMM: begin
                    w_imm    = w_imm_i;
                    w_alu_op = 3'd5;
                    w_reg_we = 1'b1;
                end
                OPC_OP: begin
                    w_imm    = w_imm_r;
                    w_alu_op = 3'd6;
                    w_reg_we = 1'b1;
                end
                default: w_illegal = 1'b1;
            endcase
        end

        if (w_illegal) begin
            w_reg_we = 1'b0;
            w_mem_rd = 1'b0;
            w_mem_wr = 1'b0;
            w_branch = 1'b0;
            w_jump   = 1'b0;
        end
        // x0 is hardwired; never request a write to it
        if (w_inst[11:7] == 5'd0) begin
            w_reg_we = 1'b0;
        end
    end

    assign w_in_ready = !r_valid || bus.out_ready;
    assign w_capture  = bus.in_valid && w_in_ready && !bus.flush;

    // Single-entry holding register; flush beats capture, capture beats drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_alu_op  <= '0;
            r_funct3  <= '0;
            r_addr_op <= '0;
            r_wb_sel  <= '0;
            r_imm     <= '0;
            r_reg_we  <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_branch  <= 1'b0;
            r_jump    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid   <= 1'b1;
            r_pc      <= bus.in_pc;
            r_rd      <= w_inst[11:7];
            r_rs1     <= w_inst[19:15];
            r_rs2     <= w_inst[24:20];
            r_alu_op  <= w_alu_op;
            r_funct3  <= w_f3;
            r_addr_op <= w_addr_op;
            r_wb_sel  <= w_wb_sel;
            r_imm     <= XLEN'(w_imm);
            r_reg_we  <= w_reg_we;
            r_mem_rd  <= w_mem_rd;
            r_mem_wr  <= w_mem_wr;
            r_branch  <= w_branch;
            r_jump    <= w_jump;
            r_illegal <= w_illegal;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_valid;
    assign bus.out_pc      = r_pc;
    assign bus.rd          = r_rd;
    assign bus.rs1_addr    = r_rs1;
    assign bus.rs2_addr    = r_rs2;
    assign bus.alu_op      = r_alu_op;
    assign bus.addr_alu_op = r_addr_op;
    assign bus.funct3      = r_funct3;
    assign bus.imm         = r_imm;
    assign bus.wb_sel      = r_wb_sel;
    assign bus.reg_we      = r_reg_we;
    assign bus.mem_rd      = r_mem_rd;
    assign bus.mem_wr      = r_mem_wr;
    assign bus.branch      = r_branch;
    assign bus.jump        = r_jump;
    assign bus.illegal     = r_illegal;
endmodule
